// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions for the execute stage: opcode/funct codes, forward selects,
// ALU and mult/div operation enums, and the forwarding mux helper.
package mips_defs;

  localparam int DIV_LAT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [4:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_ANDI, ALU_ORI, ALU_XORI, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI, ALU_MEM, ALU_MFHI, ALU_MFLO
  } aluOpT;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } mdOpT;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} mdStateT;

  // Encoding 2'b11 is unused and falls back to the register-file value.
  function automatic logic [31:0] fwdSel(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] mem, input logic [31:0] wb);
    case (sel)
      FWD_MEM: fwdSel = mem;
      FWD_WB:  fwdSel = wb;
      default: fwdSel = rf;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Multi-cycle HI/LO unit: counter-driven FSM, latched operands, multiplier and a
// one-bit-per-cycle restoring divider; HI/LO are written when the count expires.
module md_unit
  import mips_defs::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_busy
);

  localparam int CNT_W = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);

  mdStateT          state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             start, isDiv, isSigned, accept, finish;
  logic [31:0]      opA, opB, rem, quo, dvs;
  logic             opSigned;
  logic [32:0]      shifted;
  logic [33:0]      trial;
  logic [31:0]      remStep, quoStep, divHi, divLo;
  logic [63:0]      extA, extB, product;

  assign start    = (mdOp == MD_MULT) || (mdOp == MD_MULTU) || (mdOp == MD_DIV) || (mdOp == MD_DIVU);
  assign isDiv    = (mdOp == MD_DIV) || (mdOp == MD_DIVU);
  assign isSigned = (mdOp == MD_MULT) || (mdOp == MD_DIV);
  assign accept   = start && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stateNext = state;
    cntNext   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        stateNext = isDiv ? S_DIV : S_MUL;
        cntNext   = isDiv ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end
      S_MUL, S_DIV: begin
        cntNext = cnt - 1'b1;
        if (cnt == CNT_W'(1)) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    md_busy = start || (state != S_IDLE);
    finish  = (state != S_IDLE) && (cnt == CNT_W'(1));
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    remStep = trial[33] ? shifted[31:0] : trial[31:0];
    quoStep = {quo[30:0], ~trial[33]};
    divLo   = (opB == '0) ? '1 : ((opSigned && (opA[31] ^ opB[31])) ? -quoStep : quoStep);
    divHi   = (opB == '0) ? opA : ((opSigned && opA[31]) ? -remStep : remStep);
    extA    = {{32{opSigned & opA[31]}}, opA};
    extB    = {{32{opSigned & opB[31]}}, opB};
    product = extA * extB;
  end

  // NOTE: operand and divider registers have no reset; they are only consumed while the FSM is busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      opA      <= srcA;
      opB      <= srcB;
      opSigned <= isSigned;
      quo      <= (isSigned && srcA[31]) ? -srcA : srcA;
      dvs      <= (isSigned && srcB[31]) ? -srcB : srcB;
      rem      <= '0;
    end else if (state == S_DIV) begin
      rem <= remStep;
      quo <= quoStep;
    end
  end

  // Completion overrides any MTHI/MTLO that slipped in while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      if (state == S_DIV) {hi, lo} <= {divHi, divLo};
      else                {hi, lo} <= product;
    end else begin
      if (mdOp == MD_MTHI) hi <= srcA;
      if (mdOp == MD_MTLO) lo <= srcA;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU decode and execute, HI/LO unit hookup,
// and the EX/MEM pipeline register.
module ex_stage
  import mips_defs::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [31:0] rd_1E,
  input  logic [31:0] rd_2E,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [31:0] SignImmE,
  input  logic [31:0] irE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM,
  output logic        md_busy
);

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] zeroImm, srcA, srcBReg, srcB, aluResult, hi, lo;
  aluOpT       aluOp;
  mdOpT        mdOp;
  logic        unusedBits;

  assign opcode     = irE[31:26];
  assign funct      = irE[5:0];
  assign shamt      = irE[10:6];
  assign zeroImm    = {16'h0000, irE[15:0]};
  assign unusedBits = ^{RsE, irE[25:16]};

  assign srcA    = fwdSel(ForwardAE, rd_1E, ALUOutM, ResultW);
  assign srcBReg = fwdSel(ForwardBE, rd_2E, ALUOutM, ResultW);
  assign srcB    = ALUSrcE ? SignImmE : srcBReg;

  always_comb begin
    aluOp = ALU_ZERO;
    mdOp  = MD_NONE;
    if (irE != '0) begin
      case (opcode)
        OP_RTYPE: case (funct)
          FN_SLL:                aluOp = ALU_SLL;
          FN_SRL:                aluOp = ALU_SRL;
          FN_SRA:                aluOp = ALU_SRA;
          FN_SLLV:               aluOp = ALU_SLLV;
          FN_SRLV:               aluOp = ALU_SRLV;
          FN_SRAV:               aluOp = ALU_SRAV;
          FN_MFHI:               aluOp = ALU_MFHI;
          FN_MFLO:               aluOp = ALU_MFLO;
          FN_MTHI:               mdOp  = MD_MTHI;
          FN_MTLO:               mdOp  = MD_MTLO;
          FN_MULT:               mdOp  = MD_MULT;
          FN_MULTU:              mdOp  = MD_MULTU;
          FN_DIV:                mdOp  = MD_DIV;
          FN_DIVU:               mdOp  = MD_DIVU;
          FN_ADD, FN_ADDU:       aluOp = ALU_ADD;
          FN_SUB, FN_SUBU:       aluOp = ALU_SUB;
          FN_AND:                aluOp = ALU_AND;
          FN_OR:                 aluOp = ALU_OR;
          FN_XOR:                aluOp = ALU_XOR;
          FN_NOR:                aluOp = ALU_NOR;
          FN_SLT:                aluOp = ALU_SLT;
          FN_SLTU:               aluOp = ALU_SLTU;
          default:               aluOp = ALU_ZERO;
        endcase
        OP_ADDI, OP_ADDIU:       aluOp = ALU_ADD;
        OP_SLTI:                 aluOp = ALU_SLT;
        OP_SLTIU:                aluOp = ALU_SLTU;
        OP_ANDI:                 aluOp = ALU_ANDI;
        OP_ORI:                  aluOp = ALU_ORI;
        OP_XORI:                 aluOp = ALU_XORI;
        OP_LUI:                  aluOp = ALU_LUI;
        OP_LW, OP_SW:            aluOp = ALU_MEM;
        default:                 aluOp = ALU_ZERO;
      endcase
    end
  end

  always_comb begin
    case (aluOp)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_NOR:  aluResult = ~(srcA | srcB);
      ALU_ANDI: aluResult = srcA & zeroImm;
      ALU_ORI:  aluResult = srcA | zeroImm;
      ALU_XORI: aluResult = srcA ^ zeroImm;
      ALU_SLT:  aluResult = {31'b0, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluResult = {31'b0, srcA < srcB};
      ALU_SLL:  aluResult = srcB << shamt;
      ALU_SRL:  aluResult = srcB >> shamt;
      ALU_SRA:  aluResult = 32'($signed(srcB) >>> shamt);
      ALU_SLLV: aluResult = srcB << srcA[4:0];
      ALU_SRLV: aluResult = srcB >> srcA[4:0];
      ALU_SRAV: aluResult = 32'($signed(srcB) >>> srcA[4:0]);
      ALU_LUI:  aluResult = {irE[15:0], 16'h0000};
      ALU_MEM:  aluResult = srcA + SignImmE;
      ALU_MFHI: aluResult = hi;
      ALU_MFLO: aluResult = lo;
      default:  aluResult = '0;
    endcase
  end

  md_unit #(.MUL_LAT(MUL_LAT)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdOp    (mdOp),
    .srcA    (srcA),
    .srcB    (srcBReg),
    .hi      (hi),
    .lo      (lo),
    .md_busy (md_busy)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= aluResult;
      WriteDataM <= srcBReg;
      WriteRegM  <= RegDstE ? RdE : RtE;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU and mult/div
// traffic compared against an arithmetic reference model of the instruction set.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [31:0] rd_1E, rd_2E, SignImmE, irE, ResultW;
  logic [4:0]  RsE, RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemtoRegM, MemWriteM, md_busy;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expM = '0;
  logic [31:0] hiM = '0;
  logic [31:0] loM = '0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
    .rd_1E(rd_1E), .rd_2E(rd_2E), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .SignImmE(SignImmE), .irE(irE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural result of one instruction given its final operands.
  function automatic logic [31:0] model(input logic [31:0] ir, a, b, imm);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (ir == '0) return '0;
    if (op == 6'h00) begin
      case (fn)
        6'h00: return b << ir[10:6];
        6'h02: return b >> ir[10:6];
        6'h03: return 32'($signed(b) >>> ir[10:6]);
        6'h04: return b << a[4:0];
        6'h06: return b >> a[4:0];
        6'h07: return 32'($signed(b) >>> a[4:0]);
        6'h10: return hiM;
        6'h12: return loM;
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: return (a < b) ? 32'd1 : 32'd0;
        default: return '0;
      endcase
    end
    case (op)
      6'h08, 6'h09: return a + b;
      6'h0A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h0B: return (a < b) ? 32'd1 : 32'd0;
      6'h0C: return a & {16'h0000, ir[15:0]};
      6'h0D: return a | {16'h0000, ir[15:0]};
      6'h0E: return a ^ {16'h0000, ir[15:0]};
      6'h0F: return {ir[15:0], 16'h0000};
      6'h23, 6'h2B: return a + imm;
      default: return '0;
    endcase
  endfunction

  task automatic mdModel(input logic [5:0] fn, input logic [31:0] a, b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (fn)
      6'h18: {hiM, loM} = sa * sb;
      6'h19: {hiM, loM} = ua * ub;
      6'h1A, 6'h1B: begin
        if (b == '0) begin
          loM = 32'hFFFFFFFF;
          hiM = a;
        end else if (fn == 6'h1A) begin
          q = sa / sb;
          r = sa % sb;
          loM = q[31:0];
          hiM = r[31:0];
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          loM = uq[31:0];
          hiM = ur[31:0];
        end
      end
      default: ;
    endcase
  endtask

  task automatic bubble();
    irE = '0; rd_1E = '0; rd_2E = '0; SignImmE = '0; ResultW = '0;
    ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    {RegWriteE, MemtoRegE, MemWriteE, RegDstE} = 4'b0000;
    RsE = '0; RtE = '0; RdE = '0;
  endtask

  // ctl = {RegWrite, MemtoReg, MemWrite, RegDst}; one instruction through E, checked in M.
  task automatic exec(input logic [31:0] ir, a, b, imm, input logic aluSrc,
                      input logic [1:0] fa, fb, input logic [31:0] resW, input logic [3:0] ctl);
    logic [31:0] sa, sbr, sb, exp;
    irE = ir; rd_1E = a; rd_2E = b; SignImmE = imm; ALUSrcE = aluSrc;
    ForwardAE = fa; ForwardBE = fb; ResultW = resW;
    {RegWriteE, MemtoRegE, MemWriteE, RegDstE} = ctl;
    RsE = ir[25:21]; RtE = ir[20:16]; RdE = ir[15:11];
    sa  = (fa == 2'b10) ? expM : (fa == 2'b01) ? resW : a;
    sbr = (fb == 2'b10) ? expM : (fb == 2'b01) ? resW : b;
    sb  = aluSrc ? imm : sbr;
    exp = model(ir, sa, sb, imm);
    @(posedge clk);
    #1;
    check("alu_out", ALUOutM, exp);
    check("write_data", WriteDataM, sbr);
    check("write_reg", 32'(WriteRegM), 32'(ctl[0] ? ir[15:11] : ir[20:16]));
    check("ctl_m", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'(ctl[3:1]));
    if (ir[31:26] == 6'h00 && ir[5:0] == 6'h11) hiM = sa;
    if (ir[31:26] == 6'h00 && ir[5:0] == 6'h13) loM = sa;
    expM = exp;
  endtask

  // Launch a mult/div, count busy cycles (bounded), bubbles behind it.
  task automatic runMd(input logic [5:0] fn, input logic [31:0] a, b, input int expBusy,
                       input string tag);
    int n;
    bubble();
    irE = rtype(5'd4, 5'd5, 5'd0, 5'd0, fn);
    rd_1E = a; rd_2E = b; RsE = 5'd4; RtE = 5'd5;
    #1;
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
      bubble();
      #1;
    end
    check({tag, "_busy"}, 32'(n), 32'(expBusy));
    mdModel(fn, a, b);
    expM = '0;
  endtask

  logic [5:0] rFn[20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13,
                          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] iOp[11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
                          6'h3F};
  logic [5:0] mdFn[4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};

  initial begin
    logic [31:0] ir, a, b;
    logic [5:0]  fn;

    // Reset state
    bubble();
    #1;
    check("rst_alu_out", ALUOutM, 32'h0);
    check("rst_ctl", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'h0);
    check("rst_busy", 32'(md_busy), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("rst_hi", ALUOutM, 32'h0);

    // ADDU then SUB with both forward paths
    exec(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 7, 5, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("addu", ALUOutM, 32'd12);
    exec(rtype(5'd3, 5'd4, 5'd5, 5'd0, 6'h22), 99, 99, 0, 1'b0, 2'b10, 2'b01, 3, 4'b1001);
    check("sub_fwd", ALUOutM, 32'd9);

    // MTHI then MFHI, SLTIU, SRA
    exec(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h11), 32'hA5A5A5A5, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b0000);
    exec(rtype(5'd0, 5'd0, 5'd6, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("mthi_mfhi", ALUOutM, 32'hA5A5A5A5);
    exec(itype(6'h0B, 5'd1, 5'd2, 16'hFFFF), 1, 0, 32'hFFFFFFFF, 1'b1, 2'b00, 2'b00, 0, 4'b1000);
    check("sltiu", ALUOutM, 32'd1);
    exec(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 0, 32'h80000000, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("sra", ALUOutM, 32'hF8000000);

    // SW with store data forwarded from M, then a bubble
    exec(itype(6'h0D, 5'd0, 5'd7, 16'h1234), 0, 0, 32'h1234, 1'b1, 2'b00, 2'b00, 0, 4'b1000);
    exec(itype(6'h2B, 5'd1, 5'd7, 16'hFFFC), 32'h100, 0, 32'hFFFFFFFC, 1'b1, 2'b00, 2'b10, 0,
         4'b0010);
    check("sw_addr", ALUOutM, 32'hFC);
    check("sw_data", WriteDataM, 32'h1234);
    check("sw_memwrite", 32'(MemWriteM), 32'd1);
    exec(32'h0, 32'hDEAD, 32'hBEEF, 32'h55, 1'b0, 2'b00, 2'b00, 0, 4'b0000);
    check("bubble_out", ALUOutM, 32'h0);
    check("bubble_regwrite", 32'(RegWriteM), 32'h0);

    // MULT and DIV/DIVU results
    runMd(6'h18, 32'hFFFFFFFD, 32'd7, 5, "mult");
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("mult_lo", ALUOutM, 32'hFFFFFFEB);
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("mult_hi", ALUOutM, 32'hFFFFFFFF);
    runMd(6'h1A, 32'hFFFFFFF9, 32'd2, 33, "div");
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("div_lo", ALUOutM, 32'hFFFFFFFD);
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("div_hi", ALUOutM, 32'hFFFFFFFF);
    runMd(6'h1B, 32'd7, 32'd0, 33, "divu0");
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("divu0_lo", ALUOutM, 32'hFFFFFFFF);
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("divu0_hi", ALUOutM, 32'd7);

    // Async reset in the middle of a DIV (count at 10)
    bubble();
    irE = rtype(5'd4, 5'd5, 5'd0, 5'd0, 6'h1A);
    rd_1E = 32'd100; rd_2E = 32'd3;
    @(posedge clk);
    #1;
    bubble();
    irE = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    rd_1E = 32'd1; rd_2E = 32'd2; RdE = 5'd3;
    {RegWriteE, MemtoRegE, MemWriteE, RegDstE} = 4'b1111;
    repeat (22) @(posedge clk);
    #1;
    check("div_mid_busy", 32'(md_busy), 32'd1);
    check("div_mid_out", ALUOutM, 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(md_busy), 32'd0);
    check("arst_alu_out", ALUOutM, 32'h0);
    check("arst_ctl", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'h0);
    check("arst_write_reg", 32'(WriteRegM), 32'h0);
    hiM = '0; loM = '0; expM = '0;
    #1 rst_n = 1'b1;
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("arst_hi", ALUOutM, 32'h0);
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    check("arst_lo", ALUOutM, 32'h0);
    runMd(6'h1A, 32'd100, 32'd3, 33, "div_after_rst");
    exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);

    // Randomized single-cycle traffic with random forwarding
    for (int i = 0; i < 200; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        ir[31:26] = 6'h00;
        ir[5:0]   = rFn[$urandom_range(0, 19)];
      end else begin
        ir[31:26] = iOp[$urandom_range(0, 10)];
      end
      exec(ir, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
    end

    // Randomized mult/div, read back through MFHI/MFLO
    for (int i = 0; i < 8; i++) begin
      fn = mdFn[$urandom_range(0, 3)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      if ($urandom_range(0, 2) == 0) b = b & 32'h0000000F;
      runMd(fn, a, b, (fn == 6'h18 || fn == 6'h19) ? 5 : 33, "rand_md");
      exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h10), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
      exec(rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h12), 0, 0, 0, 1'b0, 2'b00, 2'b00, 0, 4'b1001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
